// File: rtl/display_scanner_pkg.sv
// Shared constants for the seven-segment display scanner: hex decode table,
// segment bit positions and the per-slot state encoding.
package display_scanner_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-high {g,f,e,d,c,b,a} pattern for each hex value 0..F
  localparam logic [6:0] HEX7SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } slot_state_t;

endpackage

// File: rtl/display_scanner_hex7seg_lut.sv
// Combinational hex digit to active-high seven-segment pattern lookup.
module hex7seg_lut
  import display_scanner_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] segs
);

  assign segs = HEX7SEG[hex];

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed seven-segment driver: one shared segment bus, one anode
// per digit, a blank lead-in per slot and a per-frame input snapshot.
module display_scanner
  import display_scanner_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dps,
  input  logic [N_DIGITS-1:0]   blank_mask,
  output logic [7:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_start
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [N_DIGITS-1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic                  load_pending;
  logic [4*N_DIGITS-1:0] snap_digits;
  logic [N_DIGITS-1:0]   snap_dps;
  logic [N_DIGITS-1:0]   snap_mask;

  slot_state_t         slot_state;
  logic                take_snap;
  logic                drive;
  logic [3:0]          cur_digit;
  logic [6:0]          cur_segs;
  logic [7:0]          seg_on;
  logic [N_DIGITS-1:0] an_on;

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign slot_state = ST_DRIVE;
    end else begin : g_blank
      assign slot_state = (cnt < CNT_W'(BLANK_CYCLES)) ? ST_BLANK : ST_DRIVE;
    end
  endgenerate

  assign take_snap = en && (load_pending || (idx == IDX_LAST && cnt == CNT_LAST));
  assign drive     = en && (slot_state == ST_DRIVE) && !snap_mask[idx];
  assign cur_digit = snap_digits[4*idx +: 4];

  hex7seg_lut u_lut (
    .hex  (cur_digit),
    .segs (cur_segs)
  );

  always_comb begin
    seg_on                = 8'h00;
    seg_on[SEG_G:SEG_A]   = cur_segs;
    seg_on[SEG_DP]        = snap_dps[idx];
    an_on                 = '0;
    an_on[idx]            = 1'b1;
  end

  // Slot/digit counters, frame snapshot and registered display outputs;
  // polarity is applied by XOR with the idle pattern so both senses share logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      idx          <= '0;
      load_pending <= 1'b1;
      snap_digits  <= '0;
      snap_dps     <= '0;
      snap_mask    <= '0;
      seg          <= SEG_OFF;
      an           <= AN_OFF;
      frame_start  <= 1'b0;
    end else begin
      frame_start <= take_snap;
      seg         <= (drive ? seg_on : 8'h00) ^ SEG_OFF;
      an          <= (drive ? an_on : '0) ^ AN_OFF;
      if (en) begin
        if (cnt == CNT_LAST) begin
          cnt <= '0;
          idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      if (take_snap) begin
        snap_digits  <= digits;
        snap_dps     <= dps;
        snap_mask    <= blank_mask;
        load_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner: directed scenarios followed by
// randomized stimulus against a frame-level reference model.
module tb_display_scanner;

  localparam int N     = 4;
  localparam int RD    = 8;
  localparam int BL    = 2;
  localparam int FRAME = N * RD;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dps;
  logic [3:0]  blank_mask;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  // Model: k = number of enabled cycles since reset; m_* = snapshot on display
  int          k;
  logic [15:0] m_dig;
  logic [3:0]  m_dps;
  logic [3:0]  m_mask;

  logic [6:0] ref_lut [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  display_scanner #(
    .N_DIGITS       (N),
    .REFRESH_DIV    (RD),
    .BLANK_CYCLES   (BL),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .digits      (digits),
    .dps         (dps),
    .blank_mask  (blank_mask),
    .seg         (seg),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, actual, expected);
    end
  endtask

  task automatic model_reset();
    k      = 0;
    m_dig  = '0;
    m_dps  = '0;
    m_mask = '0;
  endtask

  // One clock: predict outputs from the model, then compare after the edge.
  // A frame is FRAME enabled cycles; a snapshot is taken on the first enabled
  // cycle after reset and on the last enabled cycle of every frame.
  task automatic apply_stimulus();
    logic [7:0]  e_seg;
    logic [3:0]  e_an;
    logic        e_fs;
    logic        s_en;
    logic [15:0] s_dig;
    logic [3:0]  s_dps, s_mask;
    logic        snap_now;
    int          slot, off;
    s_en   = en;
    s_dig  = digits;
    s_dps  = dps;
    s_mask = blank_mask;
    e_seg  = 8'hFF;
    e_an   = 4'hF;
    e_fs   = 1'b0;
    snap_now = s_en && ((k == 0) || (k % FRAME == FRAME - 1));
    if (s_en) begin
      slot = (k / RD) % N;
      off  = k % RD;
      if (off >= BL && !m_mask[slot]) begin
        e_an  = ~(4'b0001 << slot);
        e_seg = ~{m_dps[slot], ref_lut[m_dig[slot*4 +: 4]]};
      end
      e_fs = snap_now;
    end
    @(posedge clk);
    #1;
    check_output("an", 32'(an), 32'(e_an));
    check_output("seg", 32'(seg), 32'(e_seg));
    check_output("frame_start", 32'(frame_start), 32'(e_fs));
    if (snap_now) begin
      m_dig  = s_dig;
      m_dps  = s_dps;
      m_mask = s_mask;
    end
    if (s_en) k++;
  endtask

  task automatic run(input int n);
    repeat (n) apply_stimulus();
  endtask

  // Asynchronous reset: outputs must go idle before any clock edge
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_output("rst_an", 32'(an), 32'h0000000F);
    check_output("rst_seg", 32'(seg), 32'h000000FF);
    check_output("rst_fs", 32'(frame_start), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run_until(input int pos);
    int guard = 0;
    while ((k % FRAME) != pos && guard < 4 * FRAME) begin
      apply_stimulus();
      guard++;
    end
    check_output("reach_pos", 32'(k % FRAME), 32'(pos));
  endtask

  initial begin
    int r;
    rst        = 1'b1;
    en         = 1'b0;
    digits     = '0;
    dps        = '0;
    blank_mask = '0;
    model_reset();
    #12;
    check_output("init_an", 32'(an), 32'h0000000F);
    check_output("init_seg", 32'(seg), 32'h000000FF);
    rst = 1'b0;
    run(10);

    en     = 1'b1;
    digits = 16'h3A71;
    dps    = 4'b0010;
    run(40);
    digits = 16'h0000;
    run(60);
    blank_mask = 4'b0100;
    run(40);
    blank_mask = 4'b0000;

    run_until(12);
    en = 1'b0;
    run(5);
    en = 1'b1;
    run(40);

    digits = 16'h9C4E;
    dps    = 4'b1001;
    run_until(20);
    do_reset();
    run(40);

    repeat (1500) begin
      r = $urandom_range(0, 999);
      if (en && r < 20) en = 1'b0;
      else if (!en && r < 200) en = 1'b1;
      else if (r < 240) digits = 16'($urandom);
      else if (r < 270) dps = 4'($urandom);
      else if (r < 290) blank_mask = 4'($urandom);
      else if (r < 294) do_reset();
      apply_stimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
